mem_wb_stage: RTL

Memory stage of the five-stage pipeline. It consumes the fields latched by the EX/MEM pipeline register and performs the data-memory access over a req/ack handshake. It stalls the upstream stages while an access is outstanding and drives the registered MEM/WB fields into write-back. Branch/jump redirect is resolved here from the EX/MEM flags.

---
 rtl/mem_wb_stage_pkg.sv | 22 ++
 rtl/mem_wb_stage_if.sv | 51 +++++
 rtl/mem_timeout_ctr.sv | 18 +
 rtl/mem_wb_stage.sv | 107 ++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared pipeline types and defaults for the memory stage
// (FSM encoding, MEM/WB control struct, latched request controls)
package mem_wb_stage_pkg;
  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_t;
  typedef struct packed {
    logic valid;
    logic regwr;
  } wb_ctl_t;
  typedef struct packed {
    logic we;
    logic memtoreg;
    logic regwr;
  } req_ctl_t;
  function automatic logic is_memop(input logic v, input logic wr, input logic rd);
    return v & (wr | rd);
  endfunction
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: EX/MEM inputs, data-memory req/ack bus and MEM/WB outputs of the memory stage
// MEM_ALIGN_CHECK_EN adds the align_err pulse
interface mem_wb_stage_if import mem_wb_stage_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
);
  logic          ex_valid;
  logic          MemWr;
  logic          MemtoReg;
  logic          Regwr;
  logic          Branch;
  logic          Jump;
  logic          zero;
  logic [DW-1:0] ALUout;
  logic [DW-1:0] busB;
  logic [RW-1:0] Rd_data;
  logic          PCSrc;
  logic          stall;
  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic          wb_valid;
  logic          wb_Regwr;
  logic [RW-1:0] wb_Rw;
  logic [DW-1:0] wb_data;
  logic          bus_err;
`ifdef MEM_ALIGN_CHECK_EN
  logic          align_err;
`endif
  modport master (
`ifdef MEM_ALIGN_CHECK_EN
    output align_err,
`endif
    input  ex_valid, MemWr, MemtoReg, Regwr, Branch, Jump, zero, ALUout, busB, Rd_data,
    input  dmem_ack, dmem_rdata,
    output PCSrc, stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output wb_valid, wb_Regwr, wb_Rw, wb_data, bus_err
  );
  modport slave (
`ifdef MEM_ALIGN_CHECK_EN
    input  align_err,
`endif
    output ex_valid, MemWr, MemtoReg, Regwr, Branch, Jump, zero, ALUout, busB, Rd_data,
    output dmem_ack, dmem_rdata,
    input  PCSrc, stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  wb_valid, wb_Regwr, wb_Rw, wb_data, bus_err
  );
endinterface

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: counts WAIT cycles and flags the last one allowed before a bus timeout
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic Resetn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge CLK) begin
    if (!Resetn || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + CW'(1);
  end
  assign o_expire = i_en & (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: pipeline memory stage with req/ack data access, stall, redirect and MEM/WB register
// MEM_ALIGN_CHECK_EN rejects misaligned accesses with an align_err pulse instead of zeroing addr[1:0]
module mem_wb_stage import mem_wb_stage_pkg::*; #(
  parameter int DW      = DW_DEF,
  parameter int RW      = RW_DEF,
  parameter int TIMEOUT = 16
) (
  input logic            CLK,
  input logic            Resetn,
  mem_wb_stage_if.master bus
);
  mem_state_t    r_state, w_state_nxt;
  req_ctl_t      r_ctl;
  logic [DW-1:0] r_addr, r_wdata;
  logic [RW-1:0] r_rd;
  wb_ctl_t       r_wb, w_wb_nxt;
  logic [RW-1:0] r_wb_rw, w_wb_rw_nxt;
  logic [DW-1:0] r_wb_data, w_wb_data_nxt;
  logic          r_bus_err;
  logic          w_memop, w_misalign, w_idle, w_wait;
  logic          w_accept, w_pass, w_done, w_expire, w_timeout;

  assign w_idle    = r_state == S_IDLE;
  assign w_wait    = r_state == S_WAIT;
  assign w_memop   = is_memop(bus.ex_valid, bus.MemWr, bus.MemtoReg);
  assign w_accept  = w_idle & w_memop & ~w_misalign;
  assign w_pass    = w_idle & ~w_memop;
  assign w_done    = w_wait & bus.dmem_ack;
  assign w_timeout = w_wait & ~bus.dmem_ack & w_expire;

`ifdef MEM_ALIGN_CHECK_EN
  logic r_align_err;
  assign w_misalign = w_memop & (bus.ALUout[1:0] != 2'b00);
  always_ff @(posedge CLK) begin
    if (!Resetn) r_align_err <= 1'b0;
    else r_align_err <= w_idle & w_misalign;
  end
  assign bus.align_err = r_align_err;
`else
  assign w_misalign = 1'b0;
`endif

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .CLK     (CLK),
    .Resetn  (Resetn),
    .i_clr   (w_accept),
    .i_en    (w_wait),
    .o_expire(w_expire)
  );

  // ack takes priority over an expiring counter in the same cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_wb_nxt      = '0;
    w_wb_rw_nxt   = r_wb_rw;
    w_wb_data_nxt = r_wb_data;
    if (w_accept) w_state_nxt = S_WAIT;
    else if (w_done || w_timeout) w_state_nxt = S_IDLE;
    if (w_pass) begin
      w_wb_nxt      = '{valid: bus.ex_valid, regwr: bus.ex_valid & bus.Regwr};
      w_wb_rw_nxt   = bus.Rd_data;
      w_wb_data_nxt = bus.ALUout;
    end else if (w_done) begin
      w_wb_nxt      = '{valid: 1'b1, regwr: r_ctl.regwr & ~r_ctl.we};
      w_wb_rw_nxt   = r_rd;
      w_wb_data_nxt = r_ctl.memtoreg ? bus.dmem_rdata : r_addr;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Resetn) begin
      r_state   <= S_IDLE;
      r_ctl     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd      <= '0;
      r_wb      <= '0;
      r_wb_rw   <= '0;
      r_wb_data <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wb      <= w_wb_nxt;
      r_wb_rw   <= w_wb_rw_nxt;
      r_wb_data <= w_wb_data_nxt;
      r_bus_err <= w_timeout;
      if (w_accept) begin
        r_ctl   <= '{we: bus.MemWr, memtoreg: bus.MemtoReg, regwr: bus.Regwr};
        r_addr  <= bus.ALUout;
        r_wdata <= bus.busB;
        r_rd    <= bus.Rd_data;
      end
    end
  end

  assign bus.PCSrc      = bus.ex_valid & ((bus.Branch & bus.zero) | bus.Jump);
  assign bus.stall      = w_accept | (w_wait & ~bus.dmem_ack);
  assign bus.dmem_req   = w_wait;
  assign bus.dmem_we    = r_ctl.we;
  assign bus.dmem_addr  = {r_addr[DW-1:2], 2'b00};
  assign bus.dmem_wdata = r_wdata;
  assign bus.wb_valid   = r_wb.valid;
  assign bus.wb_Regwr   = r_wb.regwr;
  assign bus.wb_Rw      = r_wb_rw;
  assign bus.wb_data    = r_wb_data;
  assign bus.bus_err    = r_bus_err;
endmodule
